// File: rtl/reg_file_sb.sv
// Parametrised integer register file with NUM_RD async read ports, dual write-back,
// pending-write scoreboard and post-reset clear sweep. Optional: REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned DEBUG_REG  = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         init_done,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    input  logic                         wb0_en,
    input  logic [ADDR_WIDTH-1:0]        wb0_addr,
    input  logic [DATA_WIDTH-1:0]        wb0_data,
    input  logic                         wb1_en,
    input  logic [ADDR_WIDTH-1:0]        wb1_addr,
    input  logic [DATA_WIDTH-1:0]        wb1_data,
    output logic [DATA_WIDTH-1:0]        a0
);
    localparam int unsigned           DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DBG_IDX  = ADDR_WIDTH'(DEBUG_REG);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_idx;
    logic                  r_init_done;
    logic [DEPTH-1:0]      r_busy;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_run;
    logic w_wb0_we;
    logic w_wb1_we;
    logic w_issue_we;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Write/issue qualifiers: ignored during the sweep and dropped for a hardwired x0.
    assign w_run      = (r_state == ST_RUN);
    assign w_wb0_we   = w_run && wb0_en && !is_zero(wb0_addr);
    assign w_wb1_we   = w_run && wb1_en && !is_zero(wb1_addr);
    assign w_issue_we = w_run && issue_en && !is_zero(issue_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_clr_idx   <= '0;
            r_init_done <= 1'b0;
            r_busy      <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_idx <= r_clr_idx + ADDR_WIDTH'(1);
                    if (r_clr_idx == LAST_IDX) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A same-cycle issue means a newer producer is outstanding, so set wins.
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (w_issue_we && (issue_addr == ADDR_WIDTH'(i))) begin
                            r_busy[i] <= 1'b1;
                        end else if ((w_wb0_we && (wb0_addr == ADDR_WIDTH'(i))) ||
                                     (w_wb1_we && (wb1_addr == ADDR_WIDTH'(i)))) begin
                            r_busy[i] <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Storage has no reset; the sweep clears it. wb1 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_clr_idx] <= '0;
        end else begin
            if (w_wb0_we) r_mem[wb0_addr] <= wb0_data;
            if (w_wb1_we) r_mem[wb1_addr] <= wb1_data;
        end
    end

    assign init_done = r_init_done;
    assign a0        = r_mem[DBG_IDX];

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_stored;
        logic                  w_force0;

        assign w_addr   = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_stored = r_mem[w_addr];
        assign w_force0 = !w_run || is_zero(w_addr);
`ifdef REGFILE_BYPASS_EN
        logic w_hit0;
        logic w_hit1;

        assign w_hit0 = w_wb0_we && (wb0_addr == w_addr);
        assign w_hit1 = w_wb1_we && (wb1_addr == w_addr);
        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = w_force0 ? '0 :
                                                     w_hit1   ? wb1_data :
                                                     w_hit0   ? wb0_data : w_stored;
        assign rd_busy[g] = w_run && r_busy[w_addr] && !(w_hit0 || w_hit1);
`else
        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = w_force0 ? '0 : w_stored;
        assign rd_busy[g] = w_run && r_busy[w_addr];
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: sweep timing, table-driven write/scoreboard vectors,
// bypass timing and asynchronous reset mid-run.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        wb0_en;
    logic [4:0]  wb0_addr;
    logic [31:0] wb0_data;
    logic        wb1_en;
    logic [4:0]  wb1_addr;
    logic [31:0] wb1_data;
    logic [31:0] a0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .a0(a0)
    );

    typedef struct {
        logic        wb0_en;
        logic [4:0]  wb0_addr;
        logic [31:0] wb0_data;
        logic        wb1_en;
        logic [4:0]  wb1_addr;
        logic [31:0] wb1_data;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic        exp_b0;
        logic        exp_b1;
        logic [31:0] exp_a0;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [31:0] a0;
    } exp_t;

    vec_t vecs [10];
    exp_t sb_q [$];

    function automatic vec_t mk(
        input logic e0, input logic [4:0] ad0, input logic [31:0] dt0,
        input logic e1, input logic [4:0] ad1, input logic [31:0] dt1,
        input logic ie, input logic [4:0] ia,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] x0, input logic [31:0] x1,
        input logic b0, input logic b1, input logic [31:0] xa);
        vec_t v;
        v.wb0_en = e0; v.wb0_addr = ad0; v.wb0_data = dt0;
        v.wb1_en = e1; v.wb1_addr = ad1; v.wb1_data = dt1;
        v.iss_en = ie; v.iss_addr = ia;
        v.ra0 = r0; v.ra1 = r1;
        v.exp_d0 = x0; v.exp_d1 = x1; v.exp_b0 = b0; v.exp_b1 = b1; v.exp_a0 = xa;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        wb0_en = 1'b0; wb1_en = 1'b0; issue_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until init_done; returns the count (bounded).
    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 100) begin
            tick();
            n++;
            if (n == 20) clear_ctl();
        end
    endtask

    initial begin
        int   n;
        exp_t e;

        reset = 1'b1; rd_addr = '0;
        issue_en = 1'b0; issue_addr = '0;
        wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;

        vecs[0] = mk(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 7, 0, 32'h22222222, 0, 0, 0, 0);
        vecs[1] = mk(1, 10, 32'h5, 0, 0, 0, 0, 0, 10, 7, 32'h5, 32'h22222222, 0, 0, 32'h5);
        vecs[2] = mk(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 32'h5);
        vecs[3] = mk(0, 0, 0, 0, 0, 0, 1, 3, 3, 7, 0, 32'h22222222, 1, 0, 32'h5);
        vecs[4] = mk(1, 3, 32'hAAAA, 0, 0, 0, 1, 3, 3, 3, 32'hAAAA, 32'hAAAA, 1, 1, 32'h5);
        vecs[5] = mk(0, 0, 0, 1, 3, 32'hBBBB, 0, 0, 3, 7, 32'hBBBB, 32'h22222222, 0, 0, 32'h5);
        vecs[6] = mk(1, 3, 32'hCCCC, 0, 0, 0, 0, 0, 3, 3, 32'hCCCC, 32'hCCCC, 0, 0, 32'h5);
        vecs[7] = mk(1, 12, 32'h12, 1, 13, 32'h13, 1, 9, 12, 13, 32'h12, 32'h13, 0, 0, 32'h5);
        vecs[8] = mk(0, 0, 0, 0, 0, 0, 1, 12, 12, 9, 32'h12, 0, 1, 1, 32'h5);
        vecs[9] = mk(1, 9, 32'h99, 1, 12, 32'h1212, 0, 0, 9, 12, 32'h99, 32'h1212, 0, 0, 32'h5);

        // Reset state and sweep latency, with writes/issue attempted during the sweep.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_init_done", 32'(init_done), 32'h0);
        chk("reset_rd_busy", 32'(rd_busy), 32'h0);
        reset = 1'b0;
        wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEAD;
        issue_en = 1'b1; issue_addr = 5'd6;
        rd_addr = {5'd6, 5'd5};
        tick();
        chk("init_rd_data", rd_data[31:0], 32'h0);
        wait_init(n);
        n++;
        clear_ctl();
        chk("sweep_cycles", 32'(n), 32'd32);
        #1;
        chk("x5_after_init", rd_data[31:0], 32'h0);
        chk("x6_busy_after_init", 32'(rd_busy), 32'h0);

        // Table-driven vectors; expected results queued at drive, popped after the edge.
        for (int i = 0; i < 10; i++) begin
            wb0_en = vecs[i].wb0_en; wb0_addr = vecs[i].wb0_addr; wb0_data = vecs[i].wb0_data;
            wb1_en = vecs[i].wb1_en; wb1_addr = vecs[i].wb1_addr; wb1_data = vecs[i].wb1_data;
            issue_en = vecs[i].iss_en; issue_addr = vecs[i].iss_addr;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            e.d0 = vecs[i].exp_d0; e.d1 = vecs[i].exp_d1;
            e.b0 = vecs[i].exp_b0; e.b1 = vecs[i].exp_b1; e.a0 = vecs[i].exp_a0;
            sb_q.push_back(e);
            tick();
            clear_ctl();
            #1;
            e = sb_q.pop_front();
            chk($sformatf("v%0d_d0", i), rd_data[31:0], e.d0);
            chk($sformatf("v%0d_d1", i), rd_data[63:32], e.d1);
            chk($sformatf("v%0d_b0", i), 32'(rd_busy[0]), 32'(e.b0));
            chk($sformatf("v%0d_b1", i), 32'(rd_busy[1]), 32'(e.b1));
            chk($sformatf("v%0d_a0", i), a0, e.a0);
        end

        // Same-cycle read of a register being written back.
        rd_addr = {5'd4, 5'd4};
        issue_en = 1'b1; issue_addr = 5'd4;
        tick();
        clear_ctl();
        #1;
        chk("byp_pre_busy", 32'(rd_busy[1]), 32'h1);
        wb0_en = 1'b1; wb0_addr = 5'd4; wb0_data = 32'hABCD;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_data", rd_data[63:32], 32'hABCD);
        chk("byp_same_busy", 32'(rd_busy[1]), 32'h0);
`else
        chk("byp_same_data", rd_data[63:32], 32'h0);
        chk("byp_same_busy", 32'(rd_busy[1]), 32'h1);
`endif
        tick();
        clear_ctl();
        #1;
        chk("byp_next_data", rd_data[63:32], 32'hABCD);
        chk("byp_next_busy", 32'(rd_busy[1]), 32'h0);

        // Asynchronous reset in the middle of normal operation.
        wb0_en = 1'b1; wb0_addr = 5'd8; wb0_data = 32'h1234;
        tick();
        clear_ctl();
        issue_en = 1'b1; issue_addr = 5'd8;
        tick();
        issue_addr = 5'd14;
        tick();
        clear_ctl();
        rd_addr = {5'd14, 5'd8};
        #1;
        chk("mid_x8_data", rd_data[31:0], 32'h1234);
        chk("mid_busy", 32'(rd_busy), 32'h3);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_init_done", 32'(init_done), 32'h0);
        chk("async_rd_busy", 32'(rd_busy), 32'h0);
        chk("async_rd_data", rd_data[31:0], 32'h0);
        tick();
        tick();
        reset = 1'b0;
        wait_init(n);
        chk("resweep_cycles", 32'(n), 32'd32);
        #1;
        chk("x8_after_resweep", rd_data[31:0], 32'h0);
        chk("busy_after_resweep", 32'(rd_busy), 32'h0);
        chk("a0_after_resweep", a0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor of the integer register file for the pipelined RISC-V core.
- Provides NUM_RD asynchronous read ports and two write-back ports: wb0 for ALU, wb1 for load.
- Keeps a per-register pending-write scoreboard for hazard detection.
- After reset, clears the array with a sequential sweep FSM instead of a wide reset, and exposes the debug register (a0) for the testbench.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes and issues to it dropped); 0 = ordinary register
DEBUG_REG, 10, index mirrored on a0

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
init_done  output  1  high once the clear sweep has completed
rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_RD*DATA_WIDTH  packed read data, combinational
rd_busy  output  NUM_RD  per-port flag: addressed register has a write pending
issue_en  input  1  instruction with destination issued this cycle
issue_addr  input  ADDR_WIDTH  destination to mark busy
wb0_en  input  1  ALU write-back valid
wb0_addr  input  ADDR_WIDTH  ALU destination
wb0_data  input  DATA_WIDTH  ALU result
wb1_en  input  1  load write-back valid
wb1_addr  input  ADDR_WIDTH  load destination
wb1_data  input  DATA_WIDTH  load data
a0  output  DATA_WIDTH  stored value of DEBUG_REG (no bypass)

Behaviour:
- FSM states: INIT, RUN.
- Reset asserted (any time, including mid-sweep or mid-run):
  - FSM goes to INIT; clear index = 0; init_done = 0; all busy bits = 0.
  - a0 reads 0 once the sweep has reached DEBUG_REG.
  - The array itself is not asynchronously reset.
- INIT:
  - Each clk writes 0 to entry[clear index], then increments the index.
  - After writing entry 2**ADDR_WIDTH-1, the FSM moves to RUN.
  - init_done rises on that same edge; sweep latency is 2**ADDR_WIDTH cycles after reset deasserts.
  - wb0, wb1 and issue are ignored.
  - rd_data reads all 0; rd_busy reads all 0.
- RUN writes:
  - Synchronous on the clk edge.
  - wb0 and wb1 may both write in the same cycle.
  - If both target the same address, wb1 (load) wins.
  - With ZERO_REG=1, address 0 is never written and always reads 0.
- RUN reads:
  - rd_data[k] = entry[rd_addr[k]], combinational.
  - Write-through bypass is governed by the optional feature below.
- Scoreboard: one busy bit per entry.
  - issue_en sets busy[issue_addr] at the edge (ignored for address 0 when ZERO_REG=1).
  - A valid write on either wb port clears busy[wb addr].
  - Issue and write-back to the same address in the same cycle: busy stays 1, because a newer producer is outstanding.
  - Write-back to a non-busy register is legal; busy stays 0.
- rd_busy[k] = busy[rd_addr[k]] (the registered bit).
  - With bypass enabled, it is masked to 0 when a same-cycle write-back targets rd_addr[k].
- a0 = entry[DEBUG_REG], stored value only; it updates the cycle after a write.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - rd_data[k] returns the write-back data when wb0/wb1 is valid to rd_addr[k] in the same cycle; wb1 takes priority over wb0.
  - rd_busy[k] is masked as described above.
- Undefined:
  - rd_data returns stored contents only; new data is visible the cycle after the write.
  - rd_busy is the raw busy bit.

Test Plan:
- Reset sweep: pulse reset for 1 cycle with DATA_WIDTH=32, ADDR_WIDTH=5 → init_done low for exactly 32 cycles, then high. wb0 write of 0xDEAD to x5 attempted during INIT → x5 reads 0 after init.
- Dual write collision: wb0 (x7, 0x11111111) and wb1 (x7, 0x22222222) in the same cycle → x7 = 0x22222222. Next cycle write wb0 (x10, 0x5) → a0 = 0x5 on the following cycle.
- Zero register: wb1 writes 0xFFFFFFFF to x0 and issue_en targets x0 → rd_data for x0 = 0, rd_busy = 0.
- Scoreboard: issue x3 → rd_busy = 1 for a port reading x3. wb0 to x3 together with issue x3 in the same cycle → busy remains 1. wb1 to x3 alone → busy 0 next cycle.
- Bypass: with REGFILE_BYPASS_EN defined, wb0 (x4, 0xABCD) while port 1 reads x4 → rd_data port1 = 0xABCD in the same cycle, rd_busy = 0. Without the macro → old value this cycle, 0xABCD next cycle.
- Reset mid-run: busy bits set and x8 = 0x1234, then assert reset asynchronously (not clock-aligned) → init_done and all rd_busy drop immediately, the sweep restarts, and x8 reads 0 after init_done.
